// File: rtl/game_pkg.sv
// Shared encodings, limits and BCD helper for the game session block.
package game_pkg;

  typedef enum logic [1:0] {
    SELECT    = 2'd0,
    COUNTDOWN = 2'd1,
    INGAME    = 2'd2,
    FINISH    = 2'd3
  } game_state_e;

  localparam logic [3:0] BLANK    = 4'd12;
  localparam logic [6:0] WORD_MAX = 7'd127;
  localparam logic [7:0] ERR_MAX  = 8'd255;
  localparam logic [6:0] SEC_MAX  = 7'd127;

  // Four decimal digits, ones in [3:0]; leading zeros kept.
  function automatic logic [15:0] bcd4(input logic [12:0] v);
    logic [12:0] r;
    logic [15:0] d;
    r = v;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[i*4 +: 4] = 4'(r % 13'd10);
      r = r / 13'd10;
    end
    return d;
  endfunction

endpackage

// File: rtl/game_session_if.sv
// Controller <-> game engine interface: phase/mode/target and key events in,
// game status and display digits out.
interface game_session_if;
  import game_pkg::*;

  game_state_e state;
  logic        mode;
  logic [6:0]  target;
  logic        key_valid;
  logic        key_correct;
  logic        word_done;

  logic        finish;
  logic [6:0]  time_left;
  logic [6:0]  word_cnt;
  logic [7:0]  err_cnt;
  logic [6:0]  elapsed_s;
  logic [12:0] wpm;
  logic        wpm_valid;
  logic [15:0] disp;

  modport master (
    output state, mode, target, key_valid, key_correct, word_done,
    input  finish, time_left, word_cnt, err_cnt, elapsed_s, wpm, wpm_valid, disp
  );

  modport slave (
    input  state, mode, target, key_valid, key_correct, word_done,
    output finish, time_left, word_cnt, err_cnt, elapsed_s, wpm, wpm_valid, disp
  );
endinterface

// File: rtl/seq_divider.sv
// 13-bit restoring shift-subtract divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done lands 13 cycles after start.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] num,
  input  logic [6:0]  den,
  output logic [12:0] quo,
  output logic        done
);

  logic [6:0]  rem;
  logic [3:0]  cnt;
  logic        busy;
  logic [12:0] q_src;
  logic [7:0]  sh;
  logic        fits;
  logic [6:0]  rem_nxt;

  // One restoring step; a new start restarts from the fresh numerator.
  always_comb begin
    q_src   = start ? num : quo;
    sh      = {(start ? 7'd0 : rem), q_src[12]};
    fits    = (sh >= {1'b0, den});
    rem_nxt = fits ? 7'(sh - {1'b0, den}) : sh[6:0];
  end

  // Iteration state; done is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        if (den == 7'd0) begin
          quo  <= '0;
          rem  <= '0;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          rem  <= rem_nxt;
          quo  <= {q_src[11:0], fits};
          cnt  <= 4'd12;
          busy <= 1'b1;
        end
      end else if (busy) begin
        rem <= rem_nxt;
        quo <= {q_src[11:0], fits};
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/game_session.sv
// INGAME timing, word/error counting, end-of-game detection and WPM result.
module game_session import game_pkg::*; #(
  parameter int CLK_HZ = 100_000_000
) (
  input logic           clk,
  input logic           rst_n,
  game_session_if.slave gs
);

  localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre;
  game_state_e   st_q;
  logic          tick;
  logic          term;
  logic [12:0]   num;
  logic          div_start;
  logic          div_done;
  logic [12:0]   div_quo;
  logic [6:0]    words_left;

  assign tick       = (pre == PRE_MAX);
  // Terminal test uses registered counters; st_q==INGAME delays it one edge past entry.
  assign term       = gs.mode ? (gs.word_cnt >= gs.target) : (gs.time_left == 7'd0);
  assign num        = 13'(gs.word_cnt) * 13'd60;
  assign div_start  = (gs.state == FINISH) && (st_q != FINISH) && (gs.elapsed_s != 7'd0);
  assign words_left = (gs.target > gs.word_cnt) ? 7'(gs.target - gs.word_cnt) : 7'd0;

  seq_divider u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (num),
    .den   (gs.elapsed_s),
    .quo   (div_quo),
    .done  (div_done)
  );

  // Phase seen at the last edge: marks INGAME/FINISH entry and selects the display source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= SELECT;
    else        st_q <= gs.state;
  end

  // Game counters, finish flag and WPM result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre          <= '0;
      gs.finish    <= 1'b0;
      gs.time_left <= '0;
      gs.word_cnt  <= '0;
      gs.err_cnt   <= '0;
      gs.elapsed_s <= '0;
      gs.wpm       <= '0;
      gs.wpm_valid <= 1'b0;
    end else begin
      case (gs.state)
        INGAME: begin
          if (!gs.finish) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
              if (gs.elapsed_s != SEC_MAX) gs.elapsed_s <= gs.elapsed_s + 7'd1;
              if (!gs.mode && gs.time_left != 7'd0) gs.time_left <= gs.time_left - 7'd1;
            end
            if (gs.word_done && gs.word_cnt != WORD_MAX) gs.word_cnt <= gs.word_cnt + 7'd1;
            if (gs.key_valid && !gs.key_correct && gs.err_cnt != ERR_MAX)
              gs.err_cnt <= gs.err_cnt + 8'd1;
            if (st_q == INGAME && term) gs.finish <= 1'b1;
          end
        end
        FINISH: begin
          // Zero elapsed time short-circuits the divider.
          if (st_q != FINISH && gs.elapsed_s == 7'd0) begin
            gs.wpm       <= '0;
            gs.wpm_valid <= 1'b1;
          end else if (div_done) begin
            gs.wpm       <= div_quo;
            gs.wpm_valid <= 1'b1;
          end
        end
        default: begin
          pre          <= '0;
          gs.finish    <= 1'b0;
          gs.time_left <= gs.mode ? 7'd0 : gs.target;
          gs.word_cnt  <= '0;
          gs.err_cnt   <= '0;
          gs.elapsed_s <= '0;
          gs.wpm       <= '0;
          gs.wpm_valid <= 1'b0;
        end
      endcase
    end
  end

  // Display digits derived only from registered values, so reset shows blanks at once.
  always_comb begin
    gs.disp = {4{BLANK}};
    case (st_q)
      INGAME:  gs.disp = gs.mode ? bcd4(13'(words_left)) : bcd4(13'(gs.time_left));
      FINISH:  if (gs.wpm_valid) gs.disp = bcd4(gs.wpm);
      default: gs.disp = {4{BLANK}};
    endcase
  end

endmodule

// File: tb/tb_game_session.sv
// Bench for game_session: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_game_session;
  import game_pkg::*;

  localparam int CLK_HZ = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  game_session_if gif();

  game_session #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gs    (gif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: seconds, words, errors and result as plain integers.
  int m_tl, m_wc, m_ec, m_el, m_cyc, m_fin, m_wpm, m_wv, m_div, m_prev, m_s, m_nf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tl = 0; m_wc = 0; m_ec = 0; m_el = 0; m_cyc = 0;
      m_fin = 0; m_wpm = 0; m_wv = 0; m_div = -1; m_prev = 0;
    end else begin
      m_s = int'(gif.state);
      if (m_s < 2) begin
        m_wc = 0; m_ec = 0; m_el = 0; m_cyc = 0; m_fin = 0; m_wpm = 0; m_wv = 0; m_div = -1;
        m_tl = gif.mode ? 0 : int'(gif.target);
      end else if (m_s == 2) begin
        if (m_fin == 0) begin
          m_nf = (m_prev == 2) && (gif.mode ? (m_wc >= int'(gif.target)) : (m_tl == 0));
          m_cyc++;
          if (m_cyc == CLK_HZ) begin
            m_cyc = 0;
            if (m_el < 127) m_el++;
            if (!gif.mode && m_tl > 0) m_tl--;
          end
          if (gif.word_done && m_wc < 127) m_wc++;
          if (gif.key_valid && !gif.key_correct && m_ec < 255) m_ec++;
          m_fin = m_nf;
        end
      end else begin
        if (m_prev != 3) begin
          if (m_el == 0) begin m_wpm = 0; m_wv = 1; end
          else m_div = 13;
        end else if (m_div > 0) begin
          m_div--;
          if (m_div == 0) begin m_wpm = (m_wc * 60) / m_el; m_wv = 1; end
        end
      end
      m_prev = m_s;
    end
  end

  function automatic int exp_disp();
    int v;
    int d;
    if (m_prev == 2) begin
      v = gif.mode ? int'(gif.target) - m_wc : m_tl;
      if (v < 0) v = 0;
    end else if (m_prev == 3 && m_wv != 0) begin
      v = m_wpm;
    end else begin
      return 'hCCCC;
    end
    d = 0;
    for (int i = 0; i < 4; i++) begin
      d = d | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return d;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("finish",    int'(gif.finish),    m_fin);
    chk("time_left", int'(gif.time_left), m_tl);
    chk("word_cnt",  int'(gif.word_cnt),  m_wc);
    chk("err_cnt",   int'(gif.err_cnt),   m_ec);
    chk("elapsed_s", int'(gif.elapsed_s), m_el);
    chk("wpm",       int'(gif.wpm),       m_wpm);
    chk("wpm_valid", int'(gif.wpm_valid), m_wv);
    chk("disp",      int'(gif.disp),      exp_disp());
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic enter_game(logic md, int tg);
    gif.mode   = md;
    gif.target = 7'(tg);
    gif.state  = SELECT;
    step(2);
    gif.state = COUNTDOWN;
    step(2);
    gif.state = INGAME;
  endtask

  task automatic wait_finish(int budget, output int edges);
    edges = 0;
    while (!gif.finish && edges < budget) begin
      step(1);
      edges++;
    end
  endtask

  task automatic run_finish(string nm, int exp_lat, int exp_wpm, int exp_disp_v);
    int n;
    gif.state = FINISH;
    n = 0;
    while (!gif.wpm_valid && n < 40) begin
      step(1);
      n++;
    end
    chk({nm, "_wpm_latency"}, n, exp_lat);
    chk({nm, "_wpm_valid"}, int'(gif.wpm_valid), 1);
    chk({nm, "_wpm"}, int'(gif.wpm), exp_wpm);
    chk({nm, "_disp"}, int'(gif.disp), exp_disp_v);
    chk({nm, "_finish_held"}, int'(gif.finish), 1);
  endtask

  task automatic to_select(string nm);
    gif.state = SELECT;
    step(1);
    chk({nm, "_sel_finish"}, int'(gif.finish), 0);
    chk({nm, "_sel_words"}, int'(gif.word_cnt), 0);
    chk({nm, "_sel_elapsed"}, int'(gif.elapsed_s), 0);
    chk({nm, "_sel_wpm_valid"}, int'(gif.wpm_valid), 0);
    chk({nm, "_sel_disp"}, int'(gif.disp), 'hCCCC);
  endtask

  initial begin
    int e;
    gif.state       = SELECT;
    gif.mode        = 1'b0;
    gif.target      = 7'd0;
    gif.key_valid   = 1'b0;
    gif.key_correct = 1'b0;
    gif.word_done   = 1'b0;
    #1 rst_n = 1'b0;
    step(2);
    chk("reset_finish", int'(gif.finish), 0);
    chk("reset_disp", int'(gif.disp), 'hCCCC);
    rst_n = 1'b1;
    step(1);

    // 1: time mode, 15 s, no keys
    enter_game(1'b0, 15);
    step(1);
    chk("t1_time_left_entry", int'(gif.time_left), 15);
    chk("t1_disp_entry", int'(gif.disp), 'h0015);
    wait_finish(400, e);
    chk("t1_finish_edge", e + 1, 151);
    chk("t1_time_left", int'(gif.time_left), 0);
    chk("t1_elapsed", int'(gif.elapsed_s), 15);
    run_finish("t1", 14, 0, 'h0000);
    to_select("t1");

    // 2: word mode, 25 words over 30 s
    enter_game(1'b1, 25);
    for (e = 1; e <= 400; e++) begin
      gif.word_done = ((e % 12 == 0) && e <= 288) || e == 305;
      step(1);
      if (gif.finish) break;
    end
    gif.word_done = 1'b0;
    chk("t2_finish_edge", e, 306);
    chk("t2_words", int'(gif.word_cnt), 25);
    chk("t2_elapsed", int'(gif.elapsed_s), 30);
    run_finish("t2", 14, 50, 'h0050);
    to_select("t2");

    // 3: final word on a tick edge, then ignored words
    enter_game(1'b1, 3);
    for (e = 1; e <= 60; e++) begin
      gif.word_done = (e == 10 || e == 20 || e == 30);
      step(1);
      if (e == 30) begin
        chk("t3_words_at_tick", int'(gif.word_cnt), 3);
        chk("t3_elapsed_at_tick", int'(gif.elapsed_s), 3);
        chk("t3_finish_not_yet", int'(gif.finish), 0);
      end
      if (gif.finish) break;
    end
    chk("t3_finish_edge", e, 31);
    gif.word_done = 1'b1;
    step(3);
    gif.word_done = 1'b0;
    step(25);
    chk("t3_words_frozen", int'(gif.word_cnt), 3);
    chk("t3_elapsed_frozen", int'(gif.elapsed_s), 3);
    run_finish("t3", 14, 60, 'h0060);
    to_select("t3");

    // 4: error counter saturation
    enter_game(1'b0, 100);
    gif.key_valid   = 1'b1;
    gif.key_correct = 1'b0;
    step(300);
    chk("t4_err_sat", int'(gif.err_cnt), 255);
    gif.key_correct = 1'b1;
    step(5);
    gif.key_valid = 1'b0;
    chk("t4_err_correct_keys", int'(gif.err_cnt), 255);
    chk("t4_elapsed", int'(gif.elapsed_s), 30);
    chk("t4_time_left", int'(gif.time_left), 70);
    gif.state = SELECT;
    step(1);

    // 5: asynchronous reset mid-game
    enter_game(1'b0, 20);
    step(75);
    chk("t5_elapsed_pre", int'(gif.elapsed_s), 7);
    chk("t5_time_left_pre", int'(gif.time_left), 13);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_elapsed", int'(gif.elapsed_s), 0);
    chk("t5_rst_time_left", int'(gif.time_left), 0);
    chk("t5_rst_finish", int'(gif.finish), 0);
    chk("t5_rst_disp", int'(gif.disp), 'hCCCC);
    gif.state = SELECT;
    step(2);
    rst_n = 1'b1;
    step(1);

    // 6: word goal of zero
    enter_game(1'b1, 0);
    step(1);
    chk("t6_finish_edge1", int'(gif.finish), 0);
    step(1);
    chk("t6_finish_edge2", int'(gif.finish), 1);
    chk("t6_elapsed", int'(gif.elapsed_s), 0);
    run_finish("t6", 1, 0, 'h0000);
    to_select("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
